// File: rtl/alu_seq_unit_if.sv
// Start/Busy/Done handshake and operand/result bus of the sequential ALU.
// master = control unit side, slave = ALU side.
interface alu_seq_unit_if;
    logic        Start;
    logic [3:0]  ALUOp;
    logic [15:0] A;
    logic [15:0] B;
    logic        Busy;
    logic        Done;
    logic [15:0] Result;
    logic [15:0] ResultHi;
    logic        Zero;
    logic        Carry;
    logic        Overflow;

    modport master (
        output Start, ALUOp, A, B,
        input  Busy, Done, Result, ResultHi, Zero, Carry, Overflow
    );

    modport slave (
        input  Start, ALUOp, A, B,
        output Busy, Done, Result, ResultHi, Zero, Carry, Overflow
    );
endinterface

// File: rtl/alu_seq_unit.sv
// Sequential 16-bit ALU: single-cycle logic/arithmetic, 16-step shift-add MUL,
// and 16-step restoring DIVU when ALU_SEQ_DIV_EN is defined.
module alu_seq_unit (
    input  logic          CLK,
    input  logic          Reset_n,
    alu_seq_unit_if.slave bus
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'b1010;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
`ifdef ALU_SEQ_DIV_EN
        ST_DIV,
`endif
        ST_MUL
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;       // {partial high / remainder, multiplier / dividend}
    logic [15:0] opd_q, opd_d;       // multiplicand or divisor
    logic [15:0] result_q, result_d;
    logic [15:0] result_hi_q, result_hi_d;
    logic        carry_q, carry_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;

    // Single-cycle operation results.
    logic [15:0] sc_res;
    logic        sc_carry;
    logic        sc_ovf;
    logic [16:0] add_sum;
    logic [16:0] sub_diff;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        sc_res   = 16'h0000;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        add_sum  = {1'b0, bus.A} + {1'b0, bus.B};
        sub_diff = {1'b0, bus.A} - {1'b0, bus.B};
        case (bus.ALUOp)
            OP_ADD: begin
                sc_res   = add_sum[15:0];
                sc_carry = add_sum[16];
                sc_ovf   = (bus.A[15] == bus.B[15]) && (add_sum[15] != bus.A[15]);
            end
            OP_SUB: begin
                sc_res   = sub_diff[15:0];
                sc_carry = ~sub_diff[16];
                sc_ovf   = (bus.A[15] != bus.B[15]) && (sub_diff[15] != bus.A[15]);
            end
            OP_AND:  sc_res = bus.A & bus.B;
            OP_OR:   sc_res = bus.A | bus.B;
            OP_XOR:  sc_res = bus.A ^ bus.B;
            OP_SLL:  sc_res = bus.A << bus.B[3:0];
            OP_SRL:  sc_res = bus.A >> bus.B[3:0];
            OP_SRA:  sc_res = $unsigned($signed(bus.A) >>> bus.B[3:0]);
            OP_SLT:  sc_res = {15'h0000, $signed(bus.A) < $signed(bus.B)};
            default: sc_res = 16'h0000;
        endcase
    end

    // One shift-add step: conditional add into the high half, then shift right with carry.
    logic [16:0] mul_sum;
    logic [31:0] mul_step;
    assign mul_sum  = {1'b0, acc_q[31:16]} + (acc_q[0] ? {1'b0, opd_q} : 17'd0);
    assign mul_step = {mul_sum, acc_q[15:1]};

`ifdef ALU_SEQ_DIV_EN
    // One restoring step: shift next dividend bit into the remainder, subtract if it fits.
    logic [16:0] div_shift;
    logic [16:0] div_diff;
    logic        div_fits;
    logic [31:0] div_step;
    assign div_shift = {acc_q[31:16], acc_q[15]};
    assign div_diff  = div_shift - {1'b0, opd_q};
    assign div_fits  = div_shift >= {1'b0, opd_q};
    assign div_step  = div_fits ? {div_diff[15:0], acc_q[14:0], 1'b1}
                                : {div_shift[15:0], acc_q[14:0], 1'b0};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opd_d       = opd_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    if (bus.ALUOp == OP_MUL) begin
                        state_d = ST_MUL;
                        cnt_d   = 4'd0;
                        acc_d   = {16'h0000, bus.B};
                        opd_d   = bus.A;
                    end
`ifdef ALU_SEQ_DIV_EN
                    else if (bus.ALUOp == OP_DIVU) begin
                        if (bus.B == 16'h0000) begin
                            result_d    = 16'hFFFF;
                            result_hi_d = bus.A;
                            carry_d     = 1'b0;
                            ovf_d       = 1'b1;
                            done_d      = 1'b1;
                        end else begin
                            state_d = ST_DIV;
                            cnt_d   = 4'd0;
                            acc_d   = {16'h0000, bus.A};
                            opd_d   = bus.B;
                        end
                    end
`endif
                    else begin
                        result_d    = sc_res;
                        result_hi_d = 16'h0000;
                        carry_d     = sc_carry;
                        ovf_d       = sc_ovf;
                        done_d      = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_d = mul_step;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d     = ST_IDLE;
                    result_d    = mul_step[15:0];
                    result_hi_d = mul_step[31:16];
                    carry_d     = |mul_step[31:16];
                    ovf_d       = 1'b0;
                    done_d      = 1'b1;
                end
            end
`ifdef ALU_SEQ_DIV_EN
            ST_DIV: begin
                acc_d = div_step;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d     = ST_IDLE;
                    result_d    = div_step[15:0];
                    result_hi_d = div_step[31:16];
                    carry_d     = 1'b0;
                    ovf_d       = 1'b0;
                    done_d      = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            acc_q       <= 32'h0000_0000;
            opd_q       <= 16'h0000;
            result_q    <= 16'h0000;
            result_hi_q <= 16'h0000;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opd_q       <= opd_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
        end
    end

    assign bus.Busy     = (state_q != ST_IDLE);
    assign bus.Done     = done_q;
    assign bus.Result   = result_q;
    assign bus.ResultHi = result_hi_q;
    assign bus.Zero     = (result_q == 16'h0000);
    assign bus.Carry    = carry_q;
    assign bus.Overflow = ovf_q;

endmodule
